// File: rtl/rst_pkg.sv
// Shared types and sizing helpers for the power-on reset sequencer.
// Combinational only (no state); no latency.
// No flow control; consumed at elaboration time by the sequencer and its bench.
package rst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    HOLD,
    WAIT_RDY,
    RUN,
    FAULT
  } por_seq_state_e;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_sync_bit.sv
// Multi-flop synchroniser bringing a single asynchronous bit into the clk domain.
// Latency: STAGES clk edges from input change to q.
// No backpressure; samples d every cycle, cleared by synchronous rst.
module rst_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; bit 0 may go metastable, later stages give it time to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_por_sequencer.sv
// Power-on reset sequencer: debounces supply-good, holds por_n low, supervises system_ready.
// Latency: por_n rises SYNC_STAGES+DEBOUNCE_CYCLES+HOLD_CYCLES edges after pwr_good_i is first sampled high.
// No backpressure; system_ready_i is a level handshake retried on timeout, sticky fault when budget spent.
module rst_por_sequencer
  import rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned READY_TIMEOUT   = 64,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pwr_good_i,
  input  logic                                   system_ready_i,
  output logic                                   por_n,
  output logic                                   running_o,
  output logic                                   fault_o,
  output logic [rst_pkg::cnt_width(MAX_RETRY)-1:0] retry_cnt_o
);

  // One shared counter sized for the longest of the three timed phases.
  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES - 1, HOLD_CYCLES - 1, READY_TIMEOUT - 1);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRY);

  localparam logic [CNT_W-1:0]   DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CNT_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  por_seq_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               por_n_q, por_n_d;
  logic               running_q, running_d;
  logic               fault_q, fault_d;
  logic               pwr_good_s;

  rst_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_pwr_good_sync (
    .clk(clk),
    .rst(rst),
    .d  (pwr_good_i),
    .q  (pwr_good_s)
  );

  // Next state, shared counter and next-state-derived outputs.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;

    // Losing supply beats everything except the sticky fault.
    if (state_q != FAULT && !pwr_good_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = DEBOUNCE;
        DEBOUNCE: if (cnt_q == DB_LAST) state_d = HOLD;
        HOLD:     if (cnt_q == HOLD_LAST) state_d = WAIT_RDY;
        WAIT_RDY: begin
          // Ready wins over a timeout landing on the same cycle.
          if (system_ready_i) begin
            state_d = RUN;
            retry_d = '0;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q < RETRY_LAST) begin
              retry_d = retry_q + 1'b1;
              state_d = HOLD;
            end else begin
              state_d = FAULT;
            end
          end
        end
        RUN:      state_d = RUN;
        FAULT:    state_d = FAULT;
        default:  state_d = IDLE;
      endcase
    end

    // Counter restarts on any state change and saturates rather than wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q inside {DEBOUNCE, HOLD, WAIT_RDY}) && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end

    por_n_d   = (state_d == WAIT_RDY) || (state_d == RUN);
    running_d = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      por_n_q   <= 1'b0;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      por_n_q   <= por_n_d;
      running_q <= running_d;
      fault_q   <= fault_d;
    end
  end

  assign por_n       = por_n_q;
  assign running_o   = running_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_rst_por_sequencer.sv
// Scoreboard bench for rst_por_sequencer: a phase/elapsed-time model predicts outputs per edge.
// Latency: expected values are compared on the falling edge after the rising edge that produced them.
// No backpressure; the monitor drains one expectation per cycle.
module tb_rst_por_sequencer;
  import rst_pkg::*;

  localparam int SYNC  = 2;
  localparam int DB    = 16;
  localparam int HOLDC = 8;
  localparam int TO    = 64;
  localparam int MAXR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwr_good_i = 1'b0;
  logic       system_ready_i = 1'b0;
  logic       por_n;
  logic       running_o;
  logic       fault_o;
  logic [1:0] retry_cnt_o;

  always #5 clk = ~clk;

  rst_por_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLDC),
    .READY_TIMEOUT(TO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .pwr_good_i(pwr_good_i), .system_ready_i(system_ready_i),
    .por_n(por_n), .running_o(running_o), .fault_o(fault_o), .retry_cnt_o(retry_cnt_o)
  );

  typedef struct packed {
    logic       por_n;
    logic       run;
    logic       fault;
    logic [1:0] retry;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: current phase, edges spent in it (unbounded), retries, sync delay line.
  por_seq_state_e m_st = IDLE;
  int             m_el = 0;
  int             m_retry = 0;
  bit             m_pipe[$];

  task automatic model_edge(input bit r, input bit pg, input bit rdy);
    bit             pg_s;
    por_seq_state_e nx;
    exp_t           e;
    if (r) begin
      m_st = IDLE;
      m_el = 0;
      m_retry = 0;
      m_pipe = {};
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    end else begin
      pg_s = m_pipe[SYNC-1];
      nx = m_st;
      if (m_st == FAULT) nx = FAULT;
      else if (!pg_s) nx = IDLE;
      else if (m_st == IDLE) nx = DEBOUNCE;
      else if (m_st == DEBOUNCE && m_el == DB - 1) nx = HOLD;
      else if (m_st == HOLD && m_el == HOLDC - 1) nx = WAIT_RDY;
      else if (m_st == WAIT_RDY && rdy) begin
        nx = RUN;
        m_retry = 0;
      end else if (m_st == WAIT_RDY && m_el == TO - 1) begin
        if (m_retry < MAXR) begin
          m_retry++;
          nx = HOLD;
        end else begin
          nx = FAULT;
        end
      end
      m_el = (nx != m_st) ? 0 : m_el + 1;
      m_st = nx;
      m_pipe.push_front(pg);
      void'(m_pipe.pop_back());
    end
    e.por_n = (m_st == WAIT_RDY) || (m_st == RUN);
    e.run   = (m_st == RUN);
    e.fault = (m_st == FAULT);
    e.retry = 2'(m_retry);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus just after the falling edge and record the prediction.
  task automatic step(input bit r, input bit pg, input bit rdy);
    @(negedge clk);
    #1;
    rst = r;
    pwr_good_i = pg;
    system_ready_i = rdy;
    model_edge(r, pg, rdy);
  endtask

  // Monitor: each falling edge checks the outputs of the preceding rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({por_n, running_o, fault_o, retry_cnt_o} !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got por_n=%b running=%b fault=%b retry=%0d, want por_n=%b running=%b fault=%b retry=%0d",
                 $time, por_n, running_o, fault_o, retry_cnt_o, e.por_n, e.run, e.fault, e.retry);
      end
    end
  end

  initial begin
    int rise;
    bit pg;
    bit rdy;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);

    // Power-up, por_n release edge, ready 16 cycles after release.
    rise = -1;
    for (int k = 0; k < 60; k++) begin
      rdy = (rise >= 0) && (k >= rise + 16);
      step(1'b0, 1'b1, rdy);
      @(posedge clk);
      #1;
      if (rise < 0 && por_n === 1'b1) rise = k;
    end
    vectors++;
    if (rise != SYNC + DB + HOLDC) begin
      miscompares++;
      $display("FAIL release_edge got %0d want %0d", rise, SYNC + DB + HOLDC);
    end

    // Brown-out in RUN, then a 5-cycle glitch, then a full re-qualification.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

    // Ready never arrives: three retries then the sticky fault, immune to supply drops.
    for (int i = 0; i < 26 + 4 * TO + 3 * HOLDC + 10; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'b0);

    // Ready on the final WAIT_RDY cycle after one prior timeout.
    for (int i = 0; i < 400 && m_st != RUN; i++) begin
      rdy = (m_st == WAIT_RDY) && (m_el == TO - 1) && (m_retry == 1);
      step(1'b0, 1'b1, rdy);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

    // Supply drop in RUN, re-qualify, then reset while waiting for ready.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && !(m_st == WAIT_RDY && m_el == 10); i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

    // Random soak: long supply stretches, sparse ready pulses, rare resets.
    pg = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) pg = ~pg;
      step(($urandom_range(0, 999) == 0), pg, ($urandom_range(0, 99) < 2));
    end

    // Drain outstanding expectations.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
